// File: rtl/nic_channel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nic_channel_ctrl_pkg
// Brief   : Shared constants and helpers for the NIC channel controller
//           (register map, data width, status word builder).
// Revision: 1.0  initial release
// ============================================================================
package nic_channel_ctrl_pkg;

  localparam int c_DATA_W = 64;

  // Processor-side register map
  localparam logic [0:1] c_NIC_ADDR_ICB = 2'b00;  // input channel buffer (read)
  localparam logic [0:1] c_NIC_ADDR_ICS = 2'b01;  // input channel status (read)
  localparam logic [0:1] c_NIC_ADDR_OCB = 2'b10;  // output channel buffer (write)
  localparam logic [0:1] c_NIC_ADDR_OCS = 2'b11;  // output channel status (read)

  // Status word: flag sits in the last (least significant) bit, all others zero
  function automatic logic [0:c_DATA_W-1] statusWord(input logic flag);
    logic [0:c_DATA_W-1] w;
    w             = '0;
    w[c_DATA_W-1] = flag;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nic_buf_1entry.sv
`default_nettype none
// ============================================================================
// Module  : nic_buf_1entry
// Brief   : Single-entry channel buffer: data register plus full flag.
//           Load sets full and captures data; clear drops the full flag but
//           leaves the data register untouched (stale reads stay possible).
// Revision: 1.0  initial release
// ============================================================================
module nic_buf_1entry #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic              i_load,
  input  logic [0:DATA_W-1] i_loadData,
  input  logic              i_clear,
  output logic [0:DATA_W-1] o_data,
  output logic              o_full
);

  logic [0:DATA_W-1] r_data;
  logic              r_full;

  // Capture on load; clear only drops the flag. Callers never assert both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_loadData;
      r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/nic_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : nic_channel_ctrl
// Brief   : NIC between a polled processor port and one NoC router port.
//           One input and one output single-entry buffer, send/ready
//           handshakes, and a virtual-channel polarity gate on the output.
// Revision: 1.0  initial release
// ============================================================================
module nic_channel_ctrl
  import nic_channel_ctrl_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int VC_BIT = 0
) (
  input  logic              clk,
  input  logic              reset,          // asynchronous, active-low
  input  logic [0:1]        addr_nic,
  input  logic [0:DATA_W-1] din_nic,
  output logic [0:DATA_W-1] dout_nic,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  logic              w_cpuRead;
  logic              w_cpuWrite;
  logic              w_icbLoad;
  logic              w_icbClear;
  logic              w_ocbLoad;
  logic [0:DATA_W-1] w_icbData;
  logic [0:DATA_W-1] w_ocbData;
  logic              w_icbFull;
  logic              w_ocbFull;

  assign w_cpuRead  = nicEn && !nicWrEn;
  assign w_cpuWrite = nicEn && nicWrEn;

  // Router may only push while the input buffer is empty
  assign net_ri     = !w_icbFull;
  assign w_icbLoad  = net_si && net_ri;
  // A processor read of a full ICB consumes the packet
  assign w_icbClear = w_cpuRead && (addr_nic == c_NIC_ADDR_ICB) && w_icbFull;
  // Writes to a full OCB are dropped; software polls status first
  assign w_ocbLoad  = w_cpuWrite && (addr_nic == c_NIC_ADDR_OCB) && !w_ocbFull;

  // Output offered only when the packet's VC tag matches the router phase
  assign net_so = w_ocbFull && net_ro && (w_ocbData[VC_BIT] == net_polarity);
  assign net_do = w_ocbFull ? w_ocbData : '0;

  nic_buf_1entry #(.DATA_W(DATA_W)) u_icb (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_icbLoad),
    .i_loadData(net_di),
    .i_clear   (w_icbClear),
    .o_data    (w_icbData),
    .o_full    (w_icbFull)
  );

  nic_buf_1entry #(.DATA_W(DATA_W)) u_ocb (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_ocbLoad),
    .i_loadData(din_nic),
    .i_clear   (net_so),
    .o_data    (w_ocbData),
    .o_full    (w_ocbFull)
  );

  // Processor read mux; zero whenever no read is in progress
  always_comb begin
    dout_nic = '0;
    if (w_cpuRead) begin
      case (addr_nic)
        c_NIC_ADDR_ICB: dout_nic = w_icbData;
        c_NIC_ADDR_ICS: dout_nic = statusWord(w_icbFull);
        c_NIC_ADDR_OCS: dout_nic = statusWord(w_ocbFull);
        default:        dout_nic = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
